spi_ram_slave_p: RTL and testbench
==================================

Name: spi_ram_slave_p

Overview:
- Parametrised successor of the team's SPI-slave-plus-RAM pair, combining both in one block.
- A serial SPI-style frame protocol, sampled on the system clock, writes and reads a single-port synchronous RAM of configurable depth and width.
- Adds optional address auto-increment for burst access.
- Adds defined abort-on-deselect behaviour.
- Sits at the chip edge between the SPI pins and on-chip storage.

Parameters:
- MEM_DEPTH, 256: number of RAM words. Must be 2 or more.
- DATA_W, 8: RAM word width in bits.
- ADDR_W, $clog2(MEM_DEPTH): address width in bits.
- AUTO_INC, 0: when 1, the write address increments after each data write and the read address increments after each data read. Addresses wrap modulo MEM_DEPTH.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ss_n  in  1  slave select, active low. Frame boundary.
- mosi  in  1  serial data in, MSB first, sampled on clk.
- miso  out  1  serial read data out, MSB first.

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Frame format:
  - FW = max(ADDR_W, DATA_W). FRAME_W = 2 + FW.
  - cmd is frame[FRAME_W-1:FRAME_W-2]. The payload is right-aligned; unused upper payload bits are ignored.
  - One frame is accepted per ss_n low period.
- Commands:
  - 00 sets wr_addr.
  - 01 writes mem[wr_addr] <= payload[DATA_W-1:0].
  - 10 sets rd_addr.
  - 11 reads mem[rd_addr] and shifts the word out on miso. Payload bits of a 11 frame are don't-care.
- FSM states: IDLE, CHK_CMD, WRITE, READ, READ_OUT, DONE.
  - IDLE: when ss_n=0, go to CHK_CMD at the next edge.
  - CHK_CMD: shift in mosi as frame bit 1 (bit count=1). Go to WRITE if mosi=0, READ if mosi=1.
  - WRITE and READ: shift in one mosi bit per clk. When the count reaches FRAME_W, pulse internal rx_valid for 1 cycle.
  - After the frame completes: cmd 11 goes to READ_OUT; every other cmd goes to DONE.
  - READ_OUT: wait for internal tx_valid, then present DATA_W bits on miso, one per clk, then go to DONE.
  - DONE: ignore mosi until ss_n=1.
  - ss_n=1 in any state returns to IDLE at the next edge. A partial frame is discarded: no rx_valid, no RAM change, no address change.
- Read latency: if the last frame bit is sampled at edge k:
  - rx_valid is high in cycle k+1.
  - The RAM registers tx_data at edge k+1, and tx_valid is high in cycle k+2.
  - miso = tx_data[DATA_W-1] from edge k+2, then the next lower bit at each edge. The LSB is held for 1 cycle, then miso returns to 0.
- Read-address state:
  - A cmd 11 with no prior 10 since reset reads from rd_addr=0.
  - rd_addr persists across frames. Repeated 11 frames reread the same word, or successive words when AUTO_INC=1.
- Auto-increment:
  - With AUTO_INC=1, the address increments by 1 on the same edge as the access.
  - MEM_DEPTH-1 wraps to 0.
  - Payload address bits at or above MEM_DEPTH wrap modulo 2^ADDR_W; addresses are not range-checked beyond that.
- miso is 0 in every state except READ_OUT's shifting window.
- Reset values: state=IDLE, miso=0, rx_valid=0, tx_valid=0, wr_addr=0, rd_addr=0, tx_data=0, bit counter=0. RAM contents are not reset.
- Reset asserted mid-frame or mid-shift-out aborts immediately. The next frame requires ss_n to be seen high after reset deasserts.
- rx_valid and tx_valid are never high together for the same frame. Only one RAM access happens per cycle, so there is no read/write collision.

Decomposition:
- Package spi_ram_pkg holds:
  - a state enum typedef (the six states);
  - cmd localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - a max() helper function for FW.
- One sub-module: spi_ram_mem.
  - Contains the RAM array, wr_addr/rd_addr registers, auto-increment logic and tx_data/tx_valid generation.
  - Driven by rx_valid and the frame.
- The top level holds the FSM, the shift-in register, the bit counter and the shift-out register.

Test Plan:
- Defaults (DATA_W=8, MEM_DEPTH=256, AUTO_INC=0) -> FRAME_W=10 in every test below.
- Write/read: frames 00_00000101, 01_10100101, 10_00000101, 11_00000000 -> after the 11 frame's last bit, miso shows 1,0,1,0,0,1,0,1 starting 2 edges later, then 0.
- Abort: write frame 01_11111111 with ss_n raised after 6 bits -> mem[wr_addr] unchanged, and a subsequent read returns the old value.
- Auto-increment (AUTO_INC=1): 00_11111111, then 01_00010001 and 01_00100010 in separate ss_n windows -> mem[255]=0x11 and mem[0]=0x22 (wrap). Reads from rd_addr 255 then return 0x11 followed by 0x22.
- Reset mid-shift-out: assert rst during the 3rd miso bit -> miso=0 next cycle, state IDLE, wr_addr=rd_addr=0, and mem contents preserved on a later read.
- Wide config (DATA_W=12, MEM_DEPTH=16) -> FRAME_W=14: write 0xABC to address 3, read back 0xABC MSB-first over 12 cycles. The upper 8 payload bits of address frames are ignored.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-framed RAM slave.
package spi_ram_pkg;

  // Frame FSM states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHK_CMD  = 3'd1,
    WRITE    = 3'd2,
    READ     = 3'd3,
    READ_OUT = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Two-bit command field at the top of every frame
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Payload width is the wider of the address and data words
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_ram_slave_p_if.sv
// SPI pin bundle: the master drives select and data-in, the slave returns data-out.
interface spi_ram_slave_p_if;
  logic ss_n;
  logic mosi;
  logic miso;

  modport master (output ss_n, output mosi, input miso);
  modport slave  (input ss_n, input mosi, output miso);
endinterface

// File: rtl/spi_ram_mem.sv
// RAM plus its write/read address registers; acts on each completed frame.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = $clog2(MEM_DEPTH),
  parameter int AUTO_INC  = 0,
  parameter int FRAME_W   = 2 + max_int(ADDR_W, DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [FRAME_W-1:0] frame,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  logic [DATA_W-1:0] mem_array [MEM_DEPTH];
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [1:0]        cmd;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;

  assign cmd     = frame[FRAME_W-1 -: 2];
  assign pl_addr = frame[ADDR_W-1:0];
  assign pl_data = frame[DATA_W-1:0];

  // Increment that wraps at the last RAM word, not at 2^ADDR_W
  function automatic logic [ADDR_W-1:0] inc_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // RAM write port; contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (!rst && rx_valid && cmd == CMD_WR_DATA)
      mem_array[wr_addr_reg] <= pl_data;
  end

  // Address registers, registered read data and its one-cycle valid
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_reg <= '0;
      rd_addr_reg <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr_reg <= pl_addr;
          CMD_WR_DATA: if (AUTO_INC != 0) wr_addr_reg <= inc_addr(wr_addr_reg);
          CMD_RD_ADDR: rd_addr_reg <= pl_addr;
          default: begin
            tx_data  <= mem_array[rd_addr_reg];
            tx_valid <= 1'b1;
            if (AUTO_INC != 0) rd_addr_reg <= inc_addr(rd_addr_reg);
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/spi_ram_slave_p.sv
// SPI-style frame slave: shifts in one frame per select window, drives the RAM
// and shifts read data back out MSB first.
module spi_ram_slave_p
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = $clog2(MEM_DEPTH),
  parameter int AUTO_INC  = 0
) (
  input logic              clk,
  input logic              rst,
  spi_ram_slave_p_if.slave spi
);

  localparam int FW      = max_int(ADDR_W, DATA_W);
  localparam int FRAME_W = 2 + FW;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int OUT_W   = $clog2(DATA_W + 1);

  state_t             state_reg;
  logic [FRAME_W-1:0] frame_reg;
  logic [FRAME_W-1:0] frame_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               rx_valid_reg;
  logic               armed_reg;
  logic               miso_reg;
  logic [DATA_W-1:0]  out_sr_reg;
  logic [OUT_W-1:0]   out_cnt_reg;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  assign frame_next = {frame_reg[FRAME_W-2:0], spi.mosi};
  assign spi.miso   = miso_reg;

  // Frame FSM, shift-in and shift-out; armed_reg forces a deselect after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      frame_reg    <= '0;
      cnt_reg      <= '0;
      rx_valid_reg <= 1'b0;
      armed_reg    <= 1'b0;
      miso_reg     <= 1'b0;
      out_sr_reg   <= '0;
      out_cnt_reg  <= '0;
    end else begin
      rx_valid_reg <= 1'b0;
      if (spi.ss_n) begin
        // Deselect aborts whatever is in flight; a partial frame is dropped
        state_reg   <= IDLE;
        cnt_reg     <= '0;
        miso_reg    <= 1'b0;
        out_cnt_reg <= '0;
        armed_reg   <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: if (armed_reg) state_reg <= CHK_CMD;
          CHK_CMD: begin
            frame_reg <= frame_next;
            cnt_reg   <= CNT_W'(1);
            state_reg <= spi.mosi ? READ : WRITE;
          end
          WRITE, READ: begin
            frame_reg <= frame_next;
            cnt_reg   <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(FRAME_W - 1)) begin
              rx_valid_reg <= 1'b1;
              state_reg    <= (frame_next[FRAME_W-1 -: 2] == CMD_RD_DATA) ? READ_OUT : DONE;
            end
          end
          READ_OUT: begin
            if (out_cnt_reg == '0) begin
              if (tx_valid) begin
                miso_reg    <= tx_data[DATA_W-1];
                out_sr_reg  <= tx_data << 1;
                out_cnt_reg <= OUT_W'(1);
              end
            end else if (out_cnt_reg == OUT_W'(DATA_W)) begin
              miso_reg    <= 1'b0;
              out_cnt_reg <= '0;
              state_reg   <= DONE;
            end else begin
              miso_reg    <= out_sr_reg[DATA_W-1];
              out_sr_reg  <= out_sr_reg << 1;
              out_cnt_reg <= out_cnt_reg + 1'b1;
            end
          end
          DONE: ;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .AUTO_INC  (AUTO_INC),
    .FRAME_W   (FRAME_W)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid_reg),
    .frame    (frame_reg),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Bench for spi_ram_slave_p: default, auto-increment and wide configurations.
module tb_spi_ram_slave_p;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic ss_n_d [3];
  logic mosi_d [3];

  always #5 clk = ~clk;

  spi_ram_slave_p_if if0 ();
  spi_ram_slave_p_if if1 ();
  spi_ram_slave_p_if if2 ();

  assign if0.ss_n = ss_n_d[0];
  assign if0.mosi = mosi_d[0];
  assign if1.ss_n = ss_n_d[1];
  assign if1.mosi = mosi_d[1];
  assign if2.ss_n = ss_n_d[2];
  assign if2.mosi = mosi_d[2];

  spi_ram_slave_p u0 (.clk(clk), .rst(rst), .spi(if0));
  spi_ram_slave_p #(.AUTO_INC(1)) u1 (.clk(clk), .rst(rst), .spi(if1));
  spi_ram_slave_p #(.MEM_DEPTH(16), .DATA_W(12)) u2 (.clk(clk), .rst(rst), .spi(if2));

  typedef struct {
    int         d;
    logic [1:0] cmd;
    logic [11:0] pl;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic miso_of(input int d);
    case (d)
      0:       return if0.miso;
      1:       return if1.miso;
      default: return if2.miso;
    endcase
  endfunction

  function automatic int frame_w(input int d);
    return (d == 2) ? 14 : 10;
  endfunction

  function automatic int data_w(input int d);
    return (d == 2) ? 12 : 8;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Select, then present the first nbits of the frame MSB first
  task automatic drive_bits(input int d, input logic [1:0] cmd, input logic [11:0] pl, input int nbits);
    int          w;
    logic [15:0] f;
    logic        hi;
    w  = frame_w(d);
    f  = (16'(cmd) << (w - 2)) | (16'(pl) & ((16'd1 << (w - 2)) - 16'd1));
    hi = 1'b0;
    @(negedge clk);
    ss_n_d[d] = 1'b0;
    mosi_d[d] = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (miso_of(d)) hi = 1'b1;
      mosi_d[d] = f[w-1-i];
    end
    check($sformatf("miso_low_in_frame d%0d cmd%0d", d, cmd), {11'b0, hi}, 12'h000);
  endtask

  task automatic end_frame(input int d);
    @(negedge clk);
    ss_n_d[d] = 1'b1;
    mosi_d[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_frame(input int d, input logic [1:0] cmd, input logic [11:0] pl);
    drive_bits(d, cmd, pl, frame_w(d));
    end_frame(d);
  endtask

  // Read frame: MSB appears two edges after the last frame bit
  task automatic read_frame(input int d, input string name);
    logic [11:0] word;
    logic [11:0] exp;
    word = '0;
    drive_bits(d, CMD_RD_DATA, 12'h000, frame_w(d));
    repeat (2) @(negedge clk);
    for (int j = 0; j < data_w(d); j++) begin
      @(negedge clk);
      word = {word[10:0], miso_of(d)};
    end
    @(negedge clk);
    check({name, "_tail"}, {11'b0, miso_of(d)}, 12'h000);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 12'h001, 12'h000);
    end else begin
      exp = exp_q.pop_front();
      check(name, word, exp);
    end
    end_frame(d);
  endtask

  initial begin
    // Default config: basic write/read, reread without auto-increment
    vecs.push_back('{0, CMD_WR_ADDR, 12'h000, 12'h000});
    vecs.push_back('{0, CMD_WR_DATA, 12'h0FF, 12'h000});
    vecs.push_back('{0, CMD_WR_ADDR, 12'h005, 12'h000});
    vecs.push_back('{0, CMD_WR_DATA, 12'h0A5, 12'h000});
    vecs.push_back('{0, CMD_RD_ADDR, 12'h005, 12'h000});
    vecs.push_back('{0, CMD_RD_DATA, 12'h000, 12'h0A5});
    vecs.push_back('{0, CMD_WR_ADDR, 12'h009, 12'h000});
    vecs.push_back('{0, CMD_WR_DATA, 12'h03C, 12'h000});
    vecs.push_back('{0, CMD_RD_ADDR, 12'h009, 12'h000});
    vecs.push_back('{0, CMD_RD_DATA, 12'h000, 12'h03C});
    vecs.push_back('{0, CMD_RD_DATA, 12'h000, 12'h03C});
    vecs.push_back('{0, CMD_RD_ADDR, 12'h005, 12'h000});
    vecs.push_back('{0, CMD_RD_DATA, 12'h000, 12'h0A5});
    // Auto-increment: writes and reads wrap from 255 to 0
    vecs.push_back('{1, CMD_WR_ADDR, 12'h0FF, 12'h000});
    vecs.push_back('{1, CMD_WR_DATA, 12'h011, 12'h000});
    vecs.push_back('{1, CMD_WR_DATA, 12'h022, 12'h000});
    vecs.push_back('{1, CMD_RD_ADDR, 12'h0FF, 12'h000});
    vecs.push_back('{1, CMD_RD_DATA, 12'h000, 12'h011});
    vecs.push_back('{1, CMD_RD_DATA, 12'h000, 12'h022});
    // Wide config: upper payload bits of address frames are ignored
    vecs.push_back('{2, CMD_WR_ADDR, 12'hA53, 12'h000});
    vecs.push_back('{2, CMD_WR_DATA, 12'hABC, 12'h000});
    vecs.push_back('{2, CMD_RD_ADDR, 12'hFF3, 12'h000});
    vecs.push_back('{2, CMD_RD_DATA, 12'h000, 12'hABC});
    vecs.push_back('{2, CMD_WR_ADDR, 12'hC47, 12'h000});
    vecs.push_back('{2, CMD_WR_DATA, 12'h123, 12'h000});
    vecs.push_back('{2, CMD_RD_ADDR, 12'h007, 12'h000});
    vecs.push_back('{2, CMD_RD_DATA, 12'h000, 12'h123});
    vecs.push_back('{2, CMD_RD_ADDR, 12'hB03, 12'h000});
    vecs.push_back('{2, CMD_RD_DATA, 12'h000, 12'hABC});

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ss_n_d[i] = 1'b1;
      mosi_d[i] = 1'b0;
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_miso d%0d", i), {11'b0, miso_of(i)}, 12'h000);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].cmd == CMD_RD_DATA) begin
        exp_q.push_back(vecs[v].exp);
        read_frame(vecs[v].d, $sformatf("vec%0d_read d%0d", v, vecs[v].d));
      end else begin
        write_frame(vecs[v].d, vecs[v].cmd, vecs[v].pl);
      end
      $display("vec %0d dut %0d cmd %0d payload %h", v, vecs[v].d, vecs[v].cmd, vecs[v].pl);
    end

    // Aborted data write and aborted address write leave RAM and rd_addr alone
    write_frame(0, CMD_WR_ADDR, 12'h005);
    drive_bits(0, CMD_WR_DATA, 12'h0FF, 6);
    end_frame(0);
    write_frame(0, CMD_RD_ADDR, 12'h005);
    drive_bits(0, CMD_RD_ADDR, 12'h009, 6);
    end_frame(0);
    exp_q.push_back(12'h0A5);
    read_frame(0, "abort_read");
    $display("abort sequence done");

    // Reset during the third shifted-out bit of 0xA5
    drive_bits(0, CMD_RD_DATA, 12'h000, 10);
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("rst_seq_bit7", {11'b0, miso_of(0)}, 12'h001);
    @(negedge clk);
    check("rst_seq_bit6", {11'b0, miso_of(0)}, 12'h000);
    @(negedge clk);
    check("rst_seq_bit5", {11'b0, miso_of(0)}, 12'h001);
    rst = 1'b1;
    @(negedge clk);
    check("rst_seq_miso_cleared", {11'b0, miso_of(0)}, 12'h000);
    rst = 1'b0;
    // Select still low after reset: no frame may start until a deselect
    mosi_d[0] = 1'b1;
    begin
      logic hi;
      hi = 1'b0;
      repeat (24) begin
        @(negedge clk);
        if (miso_of(0)) hi = 1'b1;
      end
      check("rst_seq_no_frame_without_deselect", {11'b0, hi}, 12'h000);
    end
    end_frame(0);
    exp_q.push_back(12'h0FF);
    read_frame(0, "rst_seq_rd_addr_zero");
    write_frame(0, CMD_WR_DATA, 12'h066);
    exp_q.push_back(12'h066);
    read_frame(0, "rst_seq_wr_addr_zero");
    write_frame(0, CMD_RD_ADDR, 12'h005);
    exp_q.push_back(12'h0A5);
    read_frame(0, "rst_seq_mem_preserved");
    $display("reset sequence done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
